// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply-divide unit.
// Multiplies (with optional accumulate/subtract into HI:LO) finish after a
// fixed pipeline latency. Divides use a restoring radix-2 loop, one quotient
// bit per cycle, followed by a sign fix-up cycle. HI/LO change only on a
// commit, a direct mthi/mtlo write, or reset.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             Clk,
  input  logic             Clr_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       WE,
  input  logic             Cancel,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  // Counter must reach WIDTH, the index of the divide fix-up cycle.
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t state;

  // Captured operation: raw operands for multiply, magnitudes for divide.
  // During a divide, a_r shifts left and collects quotient bits.
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   rem_r;
  logic [2*WIDTH-1:0] acc_r;
  logic               op_signed;
  logic               op_acc;
  logic               op_sub;
  logic               neg_q;
  logic               neg_r;
  logic [CW-1:0]      cnt;

  logic [2*WIDTH-1:0] mul_a_ext;
  logic [2*WIDTH-1:0] mul_b_ext;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] mul_result;
  logic [WIDTH:0]     shifted;
  logic               fits;
  logic [WIDTH-1:0]   next_rem;
  logic [WIDTH-1:0]   next_quo;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  logic               acc_accept;
  logic               is_div_op;
  logic               op_is_signed;

  assign acc_accept   = Start && !Cancel && (WE == 2'b00);
  assign is_div_op    = !Op[2] && Op[1];
  assign op_is_signed = !Op[0];

  // Multiply datapath: sign/zero-extend to 2*WIDTH so the low half of the
  // product is exact modulo 2^(2*WIDTH), then optionally accumulate.
  always_comb begin
    mul_a_ext  = op_signed ? {{WIDTH{a_r[WIDTH-1]}}, a_r} : {{WIDTH{1'b0}}, a_r};
    mul_b_ext  = op_signed ? {{WIDTH{b_r[WIDTH-1]}}, b_r} : {{WIDTH{1'b0}}, b_r};
    product    = mul_a_ext * mul_b_ext;
    mul_result = product;
    if (op_acc) begin
      mul_result = op_sub ? (acc_r - product) : (acc_r + product);
    end
  end

  // One restoring divide step plus the final sign correction of the result.
  always_comb begin
    shifted  = {rem_r, a_r[WIDTH-1]};
    fits     = (shifted >= {1'b0, b_r});
    next_rem = fits ? (shifted[WIDTH-1:0] - b_r) : shifted[WIDTH-1:0];
    next_quo = {a_r[WIDTH-2:0], fits};
    quo_fix  = neg_q ? -a_r : a_r;
    rem_fix  = neg_r ? -rem_r : rem_r;
  end

  // Control FSM with registered Busy/Done/DivZero and the HI/LO registers.
  always_ff @(posedge Clk) begin
    if (!Clr_n) begin
      state     <= S_IDLE;
      HI        <= '0;
      LO        <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivZero   <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      rem_r     <= '0;
      acc_r     <= '0;
      op_signed <= 1'b0;
      op_acc    <= 1'b0;
      op_sub    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      cnt       <= '0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (WE != 2'b00) begin
            if (WE[1]) HI <= A;
            if (WE[0]) LO <= A;
          end else if (acc_accept) begin
            op_signed <= op_is_signed;
            op_acc    <= Op[2];
            op_sub    <= Op[2] && Op[1];
            acc_r     <= {HI, LO};
            rem_r     <= '0;
            cnt       <= '0;
            Busy      <= 1'b1;
            if (is_div_op) begin
              a_r   <= (op_is_signed && A[WIDTH-1]) ? -A : A;
              b_r   <= (op_is_signed && B[WIDTH-1]) ? -B : B;
              neg_q <= op_is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_r <= op_is_signed && A[WIDTH-1];
              state <= S_DIV;
            end else begin
              a_r   <= A;
              b_r   <= B;
              state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (Cancel) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end else if (cnt == CW'(MUL_LAT - 1)) begin
            {HI, LO} <= mul_result;
            Done     <= 1'b1;
            Busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DIV: begin
          if (Cancel) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end else if (cnt == '0 && b_r == '0) begin
            Done    <= 1'b1;
            DivZero <= 1'b1;
            Busy    <= 1'b0;
            state   <= S_IDLE;
          end else if (cnt == CW'(WIDTH)) begin
            HI    <= rem_fix;
            LO    <= quo_fix;
            Done  <= 1'b1;
            Busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            a_r   <= next_quo;
            rem_r <= next_rem;
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against a
// plain-arithmetic HI/LO model kept in the bench.
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = 3;

  logic          Clk;
  logic          Clr_n;
  logic          Start;
  logic [2:0]    Op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [1:0]    WE;
  logic          Cancel;
  logic [W-1:0]  HI;
  logic [W-1:0]  LO;
  logic          Busy;
  logic          Done;
  logic          DivZero;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0]  m_hi = '0;
  logic [W-1:0]  m_lo = '0;

  muldiv_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .Clk(Clk), .Clr_n(Clr_n), .Start(Start), .Op(Op), .A(A), .B(B),
    .WE(WE), .Cancel(Cancel), .HI(HI), .LO(LO), .Busy(Busy),
    .Done(Done), .DivZero(DivZero)
  );

  // Free-running clock, 10 time units per period.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [2:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] we, input logic cn);
    Start  = st;
    Op     = op;
    A      = a;
    B      = b;
    WE     = we;
    Cancel = cn;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: result straight from the arithmetic definition.
  function automatic void modelOp(input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [63:0] res,
                                  output int lat, output logic dz);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic [63:0]     acc = {m_hi, m_lo};
    logic [63:0]     p;
    longint          q;
    longint          r;
    dz  = 1'b0;
    res = acc;
    lat = LAT;
    p   = op[0] ? 64'(ua * ub) : 64'(sa * sb);
    case (op)
      3'd0, 3'd1: res = p;
      3'd4, 3'd5: res = acc + p;
      3'd6, 3'd7: res = acc - p;
      default: begin
        if (b == '0) begin
          lat = 1;
          dz  = 1'b1;
        end else begin
          lat = W + 1;
          if (op == 3'd2) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
          end
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
  endfunction

  task automatic writeHiLo(input logic [1:0] we, input logic [W-1:0] val, input string tag);
    applyStimulus(1'b0, 3'd0, val, '0, we, 1'b0);
    tick();
    if (we[1]) m_hi = val;
    if (we[0]) m_lo = val;
    applyStimulus(1'b0, 3'd0, '0, '0, 2'b00, 1'b0);
    checkOutput({tag, " hilo"}, {HI, LO}, {m_hi, m_lo});
  endtask

  // Issue one operation, scramble inputs while busy, then check the commit.
  task automatic runOp(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input string tag);
    logic [63:0] exp_res;
    int          exp_lat;
    logic        exp_dz;
    int          cycles;
    modelOp(op, a, b, exp_res, exp_lat, exp_dz);
    applyStimulus(1'b1, op, a, b, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 2'b00, 1'b0);
    checkOutput({tag, " busy"}, 64'(Busy), 64'(1));
    checkOutput({tag, " done low"}, 64'(Done), 64'(0));
    cycles = 0;
    while (Busy === 1'b1 && cycles < 100) begin
      checkOutput({tag, " hilo hold"}, {HI, LO}, {m_hi, m_lo});
      cycles++;
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    $urandom, $urandom, 2'($urandom_range(0, 3)), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 3'd0, '0, '0, 2'b00, 1'b0);
    checkOutput({tag, " latency"}, 64'(cycles), 64'(exp_lat));
    checkOutput({tag, " done"}, 64'(Done), 64'(1));
    checkOutput({tag, " divzero"}, 64'(DivZero), 64'(exp_dz));
    checkOutput({tag, " result"}, {HI, LO}, exp_res);
    m_hi = exp_res[63:32];
    m_lo = exp_res[31:0];
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    Clr_n = 1'b0;
    applyStimulus(1'b1, 3'd0, 32'h1234, 32'h5, 2'b11, 1'b0);
    tick();
    tick();
    checkOutput("reset hilo", {HI, LO}, 64'h0);
    checkOutput("reset busy", 64'(Busy), 64'(0));
    checkOutput("reset done", 64'(Done), 64'(0));
    checkOutput("reset divzero", 64'(DivZero), 64'(0));
    Clr_n = 1'b1;
    applyStimulus(1'b0, 3'd0, '0, '0, 2'b00, 1'b0);
    tick();

    runOp(3'd0, 32'hFFFFFFFE, 32'd3, "mult neg");
    checkOutput("mult neg value", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
    tick();
    checkOutput("done one cycle", 64'(Done), 64'(0));

    writeHiLo(2'b11, 32'h0, "clear");
    runOp(3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, "maddu");
    checkOutput("maddu value", {HI, LO}, 64'hFFFFFFFE_00000001);
    runOp(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, "msubu");
    checkOutput("msubu value", {HI, LO}, 64'h0);

    runOp(3'd2, 32'hFFFFFFF9, 32'd2, "div neg");
    checkOutput("div neg value", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    runOp(3'd3, 32'd7, 32'd0, "divu zero");
    runOp(3'd2, 32'h80000000, 32'hFFFFFFFF, "div ovf");
    checkOutput("div ovf value", {HI, LO}, 64'h00000000_80000000);

    writeHiLo(2'b01, 32'h55, "mtlo");
    applyStimulus(1'b1, 3'd3, 32'd100, 32'd3, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, '0, '0, 2'b00, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    checkOutput("pre cancel busy", 64'(Busy), 64'(1));
    applyStimulus(1'b0, 3'd0, '0, '0, 2'b00, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, '0, '0, 2'b00, 1'b0);
    checkOutput("cancel busy", 64'(Busy), 64'(0));
    checkOutput("cancel done", 64'(Done), 64'(0));
    checkOutput("cancel hilo", {HI, LO}, {m_hi, m_lo});
    applyStimulus(1'b1, 3'd0, 32'h1234, 32'd2, 2'b10, 1'b0);
    tick();
    m_hi = 32'h1234;
    applyStimulus(1'b0, 3'd0, '0, '0, 2'b00, 1'b0);
    checkOutput("mthi wins start", {HI, LO}, {m_hi, m_lo});
    checkOutput("mthi no busy", 64'(Busy), 64'(0));
    tick();
    checkOutput("mthi no done", 64'(Done), 64'(0));

    applyStimulus(1'b1, 3'd0, 32'd9, 32'd9, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, '0, '0, 2'b00, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 3'd0, '0, '0, 2'b00, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, '0, '0, 2'b00, 1'b0);
    checkOutput("commit cancel done", 64'(Done), 64'(0));
    checkOutput("commit cancel hilo", {HI, LO}, {m_hi, m_lo});

    applyStimulus(1'b1, 3'd1, 32'd9, 32'd9, 2'b00, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, '0, '0, 2'b00, 1'b0);
    checkOutput("idle cancel start", 64'(Busy), 64'(0));

    applyStimulus(1'b1, 3'd0, 32'd11, 32'd13, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, '0, '0, 2'b00, 1'b0);
    tick();
    Clr_n = 1'b0;
    tick();
    Clr_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    checkOutput("midop reset hilo", {HI, LO}, 64'h0);
    checkOutput("midop reset busy", 64'(Busy), 64'(0));
    checkOutput("midop reset done", 64'(Done), 64'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("post reset no done", 64'(Done), 64'(0));
    end
    runOp(3'd1, 32'd5, 32'd6, "multu after reset");
    checkOutput("multu value", {HI, LO}, 64'd30);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 32'hFFFFFFFF;
        2: begin
          ra = $urandom_range(0, 1000);
          rb = $urandom_range(1, 50);
        end
        3: ra = 32'h80000000;
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) writeHiLo(2'($urandom_range(1, 3)), $urandom, "rand we");
      runOp(rop, ra, rb, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
